// File: rtl/mcpu_soc_audio_i2s_tx_pkg.sv
// Shared constants for the codec-port audio transmitter: default geometry,
// layout of the bus configuration register and frame-width helper.
package mcpu_soc_audio_i2s_tx_pkg;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_FIFO_AW   = 4;
  localparam int DEF_MCLK_LOG2 = 3;
  localparam int DEF_BCLK_LOG2 = 5;

  // Bit positions inside the bus audio control register
  localparam int CFG_W             = 4;
  localparam int CFG_EN_BIT        = 0;
  localparam int CFG_I2S_MODE_BIT  = 1;
  localparam int CFG_HOLD_LAST_BIT = 2;
  localparam int CFG_UR_CLR_BIT    = 3;

  typedef struct packed {
    logic ur_clr;
    logic hold_last;
    logic i2s_mode;
    logic en;
  } cfg_t;

  function automatic int frame_w(input int sample_w);
    return 2 * sample_w;
  endfunction

  function automatic cfg_t cfg_unpack(input logic [CFG_W-1:0] bus);
    cfg_t c;
    c.en        = bus[CFG_EN_BIT];
    c.i2s_mode  = bus[CFG_I2S_MODE_BIT];
    c.hold_last = bus[CFG_HOLD_LAST_BIT];
    c.ur_clr    = bus[CFG_UR_CLR_BIT];
    return c;
  endfunction

endpackage

// File: rtl/mcpu_soc_audio_fifo.sv
// Synchronous FIFO holding stereo frames between the bus producer and the serialiser.
// Read data is the current head (show-ahead); push when full / pop when empty are ignored.
module mcpu_soc_audio_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == DEPTH);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  // Pointer/level registers with synchronous reset (queued data discarded)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mcpu_soc_audio_i2s_tx.sv
// Stereo serial audio transmitter: FIFO-buffered {left,right} samples shifted out
// MSB-first on data/bclk/lrclk, left-justified or I2S framing, mclk from the core clock.
module mcpu_soc_audio_i2s_tx
  import mcpu_soc_audio_i2s_tx_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FIFO_AW   = DEF_FIFO_AW,
  parameter int MCLK_LOG2 = DEF_MCLK_LOG2,
  parameter int BCLK_LOG2 = DEF_BCLK_LOG2
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic [2*SAMPLE_W-1:0] smp_data,
  input  logic                  cfg_en,
  input  logic                  cfg_i2s_mode,
  input  logic                  cfg_hold_last,
  output logic [FIFO_AW:0]      stat_level,
  output logic                  stat_underrun,
  input  logic                  stat_underrun_clr,
  output logic                  ext_audio_mclk,
  output logic                  ext_audio_bclk,
  output logic                  ext_audio_lrclk,
  output logic                  ext_audio_data
);

  localparam int FRAME_W = frame_w(SAMPLE_W);
  localparam int BCW     = $clog2(FRAME_W);
  localparam logic [BCW-1:0]       LAST_BIT = BCW'(FRAME_W - 1);
  localparam logic [BCW-1:0]       HALF     = BCW'(SAMPLE_W);
  localparam logic [BCLK_LOG2-1:0] DIV_MAX  = '1;

  logic [CFG_W-1:0]     cfg_bus;
  cfg_t                 cfg;

  logic [BCLK_LOG2-1:0] div_q, div_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [FRAME_W-1:0]   last_q, last_d;
  logic                 mode_q, mode_d;
  logic                 dly_q, dly_d;
  logic                 ur_q, ur_d;
  logic                 mclk_q, mclk_d, bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d, data_q, data_d;

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FRAME_W-1:0]   fifo_rdata, load_val, shreg_cur;
  logic                 frame_start, bclk_fall, bit_now, mode_eff;

  // Control inputs viewed through the bus register layout
  always_comb begin
    cfg_bus                    = '0;
    cfg_bus[CFG_EN_BIT]        = cfg_en;
    cfg_bus[CFG_I2S_MODE_BIT]  = cfg_i2s_mode;
    cfg_bus[CFG_HOLD_LAST_BIT] = cfg_hold_last;
    cfg_bus[CFG_UR_CLR_BIT]    = stat_underrun_clr;
    cfg                        = cfg_unpack(cfg_bus);
  end

  assign fifo_push = smp_valid & ~fifo_full;
  assign fifo_pop  = frame_start & ~fifo_empty;

  mcpu_soc_audio_fifo #(
    .AW (FIFO_AW),
    .DW (FRAME_W)
  ) u_fifo (
    .clk   (clkrst_core_clk),
    .rst_n (clkrst_core_rst_n),
    .push  (fifo_push),
    .wdata (smp_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (stat_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame/bit events; the bit being presented is taken from the load value on
  // the frame-start cycle so the first bit is not a clock late on the pin
  always_comb begin
    frame_start = cfg.en & (div_q == '0) & (bit_cnt_q == '0);
    bclk_fall   = cfg.en & (div_q == DIV_MAX);
    load_val    = ~fifo_empty ? fifo_rdata : (cfg.hold_last ? last_q : '0);
    shreg_cur   = frame_start ? load_val : shreg_q;
    bit_now     = shreg_cur[FRAME_W-1];
    mode_eff    = frame_start ? cfg.i2s_mode : mode_q;
  end

  // Divider and bit counter, both parked at zero while disabled
  always_comb begin
    div_d     = cfg.en ? div_q + BCLK_LOG2'(1) : '0;
    bit_cnt_d = bit_cnt_q;
    if (!cfg.en)        bit_cnt_d = '0;
    else if (bclk_fall) bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BCW'(1);
  end

  // Shift register, last-frame copy, mode latch, I2S delay bit and underrun flag
  always_comb begin
    shreg_d = bclk_fall ? {shreg_cur[FRAME_W-2:0], 1'b0} : shreg_cur;
    last_d  = fifo_pop ? fifo_rdata : last_q;
    mode_d  = mode_eff;
    dly_d   = !cfg.en ? 1'b0 : (bclk_fall ? bit_now : dly_q);
    ur_d    = ur_q;
    if (frame_start && fifo_empty) ur_d = 1'b1;
    else if (cfg.ur_clr)           ur_d = 1'b0;
  end

  // Next values of the registered codec pins
  always_comb begin
    mclk_d  = cfg.en & div_q[MCLK_LOG2-1];
    bclk_d  = cfg.en & div_q[BCLK_LOG2-1];
    lrclk_d = cfg.en & (bit_cnt_q >= HALF);
    data_d  = cfg.en & (mode_eff ? dly_q : bit_now);
  end

  // State and pin registers with synchronous active-low reset
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      last_q    <= '0;
      mode_q    <= 1'b0;
      dly_q     <= 1'b0;
      ur_q      <= 1'b0;
      mclk_q    <= 1'b0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      dly_q     <= dly_d;
      ur_q      <= ur_d;
      mclk_q    <= mclk_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      data_q    <= data_d;
    end
  end

  assign smp_ready       = ~fifo_full;
  assign stat_underrun   = ur_q;
  assign ext_audio_mclk  = mclk_q;
  assign ext_audio_bclk  = bclk_q;
  assign ext_audio_lrclk = lrclk_q;
  assign ext_audio_data  = data_q;

endmodule

// File: tb/tb_mcpu_soc_audio_i2s_tx.sv
// Directed bench for the audio transmitter: a table of single-frame sessions plus
// hand-written sequences for clock periods, underrun clear, FIFO fill and reset.
module tb_mcpu_soc_audio_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: default geometry
  logic        a_valid, a_ready, a_en, a_i2s, a_hold, a_ur, a_clr;
  logic [31:0] a_data;
  logic [4:0]  a_level;
  logic        a_mclk, a_bclk, a_lrclk, a_sd;

  // DUT B: 24-bit slots, fast bclk
  logic        b_valid, b_ready, b_en, b_i2s, b_hold, b_ur, b_clr;
  logic [47:0] b_data;
  logic [2:0]  b_level;
  logic        b_mclk, b_bclk, b_lrclk, b_sd;

  mcpu_soc_audio_i2s_tx dut_a (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .smp_valid         (a_valid),
    .smp_ready         (a_ready),
    .smp_data          (a_data),
    .cfg_en            (a_en),
    .cfg_i2s_mode      (a_i2s),
    .cfg_hold_last     (a_hold),
    .stat_level        (a_level),
    .stat_underrun     (a_ur),
    .stat_underrun_clr (a_clr),
    .ext_audio_mclk    (a_mclk),
    .ext_audio_bclk    (a_bclk),
    .ext_audio_lrclk   (a_lrclk),
    .ext_audio_data    (a_sd)
  );

  mcpu_soc_audio_i2s_tx #(
    .SAMPLE_W  (24),
    .FIFO_AW   (2),
    .MCLK_LOG2 (1),
    .BCLK_LOG2 (3)
  ) dut_b (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .smp_valid         (b_valid),
    .smp_ready         (b_ready),
    .smp_data          (b_data),
    .cfg_en            (b_en),
    .cfg_i2s_mode      (b_i2s),
    .cfg_hold_last     (b_hold),
    .stat_level        (b_level),
    .stat_underrun     (b_ur),
    .stat_underrun_clr (b_clr),
    .ext_audio_mclk    (b_mclk),
    .ext_audio_bclk    (b_bclk),
    .ext_audio_lrclk   (b_lrclk),
    .ext_audio_data    (b_sd)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Capture {lrclk,data} at every bclk pin rising edge while enabled
  logic [1:0] cap_a[$];
  logic [1:0] cap_b[$];
  logic       a_bclk_p = 1'b0;
  logic       b_bclk_p = 1'b0;

  always @(negedge clk) begin
    if (!a_en) cap_a.delete();
    else if (a_bclk && !a_bclk_p) cap_a.push_back({a_lrclk, a_sd});
    if (!b_en) cap_b.delete();
    else if (b_bclk && !b_bclk_p) cap_b.push_back({b_lrclk, b_sd});
    a_bclk_p <= a_bclk;
    b_bclk_p <= b_bclk;
  end

  // Rising-edge to rising-edge period of each clock pin, in core clocks
  logic [5:0] pin_v;
  logic [5:0] pin_p = '0;
  int         cyc = 0;
  int         last_r[6] = '{default: -1};
  int         per[6] = '{default: 0};
  assign pin_v = {b_lrclk, b_bclk, b_mclk, a_lrclk, a_bclk, a_mclk};

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    pin_p <= pin_v;
    for (int i = 0; i < 6; i++) begin
      if (pin_v[i] && !pin_p[i]) begin
        if (last_r[i] >= 0) per[i] <= cyc - last_r[i];
        last_r[i] <= cyc;
      end
    end
  end

  task automatic wait_cap(input bit sel_b, input int n, output logic [63:0] w, output logic [63:0] lr);
    int t;
    logic [1:0] e;
    t  = 0;
    w  = '0;
    lr = '0;
    while (((sel_b ? cap_b.size() : cap_a.size()) < n) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(sel_b ? "cap_b_timeout" : "cap_a_timeout",
          64'(((sel_b ? cap_b.size() : cap_a.size()) >= n)), 64'd1);
    for (int i = 0; i < n; i++) begin
      e = 2'b00;
      if (!sel_b && i < cap_a.size()) e = cap_a[i];
      if (sel_b && i < cap_b.size())  e = cap_b[i];
      w  = {w[62:0], e[0]};
      lr = {lr[62:0], e[1]};
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = d;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic clr_a();
    @(negedge clk);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
  endtask

  typedef struct {
    logic        push;
    logic [31:0] smp;
    logic        i2s;
    logic        hold;
    logic [31:0] exp_word;
    logic        exp_ur;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [63:0] w, lr;

    vt[0] = '{1'b1, 32'h7000_0001, 1'b0, 1'b0, 32'h7000_0001, 1'b0};
    vt[1] = '{1'b1, 32'h7000_0001, 1'b1, 1'b0, 32'h3800_0000, 1'b0};
    vt[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vt[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h7000_0001, 1'b1};
    vt[4] = '{1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'hA5A5_0F0F, 1'b0};
    vt[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h52D2_8787, 1'b1};
    vt[6] = '{1'b1, 32'h8000_FFFF, 1'b1, 1'b0, 32'h4000_7FFF, 1'b0};
    vt[7] = '{1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0};

    rst_n   = 1'b0;
    a_valid = 1'b0; a_en = 1'b0; a_i2s = 1'b0; a_hold = 1'b0; a_clr = 1'b0; a_data = '0;
    b_valid = 1'b0; b_en = 1'b0; b_i2s = 1'b0; b_hold = 1'b0; b_clr = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", 64'(a_ready), 64'd1);
    check("rst_level", 64'(a_level), 64'd0);
    check("rst_ur",    64'(a_ur),    64'd0);
    check("rst_pins",  64'({a_mclk, a_bclk, a_lrclk, a_sd}), 64'd0);

    // One frame per session
    for (int k = 0; k < 8; k++) begin
      clr_a();
      if (vt[k].push) push_a(vt[k].smp);
      @(negedge clk);
      a_i2s  = vt[k].i2s;
      a_hold = vt[k].hold;
      a_en   = 1'b1;
      wait_cap(1'b0, 32, w, lr);
      a_en = 1'b0;
      check($sformatf("vec%0d_data", k),  w[31:0], 64'(vt[k].exp_word));
      check($sformatf("vec%0d_lrclk", k), lr[31:0], 64'h0000_FFFF);
      check($sformatf("vec%0d_ur", k),    64'(a_ur), 64'(vt[k].exp_ur));
      check($sformatf("vec%0d_level", k), 64'(a_level), 64'd0);
    end

    // Clock periods over a two-frame run; second frame underruns
    clr_a();
    push_a(32'h7000_0001);
    @(negedge clk);
    a_i2s = 1'b0;
    a_hold = 1'b0;
    a_en = 1'b1;
    repeat (1700) @(negedge clk);
    check("mclk_period",  64'(per[0]), 64'd8);
    check("bclk_period",  64'(per[1]), 64'd32);
    check("lrclk_period", 64'(per[2]), 64'd1024);
    check("ur_frame2",    64'(a_ur),   64'd1);
    a_en = 1'b0;

    // Clear without a new underrun, then clear coinciding with one
    clr_a();
    check("ur_clr", 64'(a_ur), 64'd0);
    @(negedge clk);
    a_clr = 1'b1;
    a_en  = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    a_en  = 1'b0;
    check("ur_set_wins", 64'(a_ur), 64'd1);

    // Fill FIFO with 17 offered frames while disabled
    @(negedge clk);
    a_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a_data = 32'h0100_0000 + 32'(i);
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("full_level", 64'(a_level), 64'd16);
    check("full_ready", 64'(a_ready), 64'd0);
    a_en = 1'b1;
    @(negedge clk);
    a_en = 1'b0;
    check("load_level", 64'(a_level), 64'd15);
    // Push and pop in the same cycle
    @(negedge clk);
    a_en    = 1'b1;
    a_valid = 1'b1;
    a_data  = 32'h1234_5678;
    @(negedge clk);
    a_valid = 1'b0;
    a_en    = 1'b0;
    check("pushpop_level", 64'(a_level), 64'd15);

    // Reset in the middle of a frame
    @(negedge clk);
    a_en = 1'b1;
    repeat (300) @(negedge clk);
    check("pre_rst_level", 64'(a_level), 64'd14);
    check("pre_rst_ur",    64'(a_ur),    64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pins",  64'({a_mclk, a_bclk, a_lrclk, a_sd}), 64'd0);
    check("midrst_level", 64'(a_level), 64'd0);
    check("midrst_ur",    64'(a_ur),    64'd0);
    check("midrst_ready", 64'(a_ready), 64'd1);
    a_en  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 24-bit slot instance
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 48'hABCDEF_123456;
    @(negedge clk);
    b_valid = 1'b0;
    b_en    = 1'b1;
    wait_cap(1'b1, 48, w, lr);
    check("w24_data",  w[47:0],  64'hABCDEF_123456);
    check("w24_lrclk", lr[47:0], 64'h000000_FFFFFF);
    repeat (300) @(negedge clk);
    check("w24_mclk_period",  64'(per[3]), 64'd2);
    check("w24_bclk_period",  64'(per[4]), 64'd8);
    check("w24_lrclk_period", 64'(per[5]), 64'd384);
    b_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
